// File: rtl/sobel_pkg.sv
// Shared types and constants for the Sobel output packer.
package sobel_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HDR_W  = 2'd1,
        HDR_H  = 2'd2,
        PIXELS = 2'd3
    } packer_state_t;

    localparam int unsigned PIXEL_BITS   = 8;
    localparam int unsigned SOBEL_BORDER = 2;
    localparam int unsigned COUNT_BITS   = 16;

endpackage

// File: rtl/sync_fifo.sv
// First-word-fall-through synchronous FIFO; rdata shows the head whenever !empty.
module sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset; pointers define what is valid.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/sobel_frame_packer.sv
// Buffers Sobel output bytes and streams them behind a (width, height) header
// over valid/ready, pulsing frame_done on the last pixel handshake.
module sobel_frame_packer
    import sobel_pkg::*;
#(
    parameter int unsigned DATA_BITS  = 8,
    parameter int unsigned FIFO_DEPTH = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cfg_valid,
    input  logic [PIXEL_BITS-1:0] cfg_width,
    input  logic [PIXEL_BITS-1:0] cfg_height,
    input  logic [DATA_BITS-1:0]  data_in,
    input  logic                  valid_in,
    output logic                  ready_in,
    output logic [DATA_BITS-1:0]  data_out,
    output logic                  valid_out,
    input  logic                  ready_out,
    output logic                  busy,
    output logic                  frame_done,
    output logic                  overflow
);

    packer_state_t state_q, state_d;

    logic [PIXEL_BITS-1:0] ow_q, oh_q;
    logic [PIXEL_BITS-1:0] cfg_ow, cfg_oh;
    logic [COUNT_BITS-1:0] total_q, cfg_total;
    logic [COUNT_BITS-1:0] rx_count_q, tx_count_q;
    logic                  out_pix_q;

    logic                  cfg_ok, active, rx_room, push;
    logic                  out_free, hs, pix_hs, last_hs;
    logic                  load_hdr, load_pix;
    logic [DATA_BITS-1:0]  hdr_byte;
    logic [DATA_BITS-1:0]  fifo_rdata;
    logic                  fifo_full, fifo_empty;

    assign cfg_ok    = cfg_valid
                    && (cfg_width  >= PIXEL_BITS'(SOBEL_BORDER + 1))
                    && (cfg_height >= PIXEL_BITS'(SOBEL_BORDER + 1));
    assign cfg_ow    = cfg_width  - PIXEL_BITS'(SOBEL_BORDER);
    assign cfg_oh    = cfg_height - PIXEL_BITS'(SOBEL_BORDER);
    assign cfg_total = COUNT_BITS'(cfg_ow) * COUNT_BITS'(cfg_oh);

    // ready_in depends only on registered state, never on ready_out.
    assign active   = (state_q != IDLE);
    assign rx_room  = (rx_count_q < total_q);
    assign ready_in = active && !fifo_full && rx_room;
    assign push     = valid_in && ready_in;

    // Header bytes may still sit in the output register in PIXELS; out_pix_q
    // keeps them out of the pixel count.
    assign out_free = !valid_out || ready_out;
    assign hs       = valid_out && ready_out;
    assign pix_hs   = hs && out_pix_q;
    assign last_hs  = pix_hs && (tx_count_q == total_q - COUNT_BITS'(1));

    sync_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (load_pix),
        .wdata (data_in),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Next state, output-register load selection and frame_done.
    always_comb begin
        state_d    = state_q;
        load_hdr   = 1'b0;
        load_pix   = 1'b0;
        hdr_byte   = '0;
        frame_done = 1'b0;
        case (state_q)
            IDLE: begin
                if (cfg_ok) state_d = HDR_W;
            end
            HDR_W: begin
                if (out_free) begin
                    load_hdr = 1'b1;
                    hdr_byte = DATA_BITS'(ow_q);
                    state_d  = HDR_H;
                end
            end
            HDR_H: begin
                if (out_free) begin
                    load_hdr = 1'b1;
                    hdr_byte = DATA_BITS'(oh_q);
                    state_d  = PIXELS;
                end
            end
            PIXELS: begin
                if (last_hs) begin
                    frame_done = 1'b1;
                    state_d    = IDLE;
                end else if (out_free && !fifo_empty) begin
                    load_pix = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ow_q       <= '0;
            oh_q       <= '0;
            total_q    <= '0;
            rx_count_q <= '0;
            tx_count_q <= '0;
            overflow   <= 1'b0;
            busy       <= 1'b0;
            data_out   <= '0;
            valid_out  <= 1'b0;
            out_pix_q  <= 1'b0;
        end else begin
            busy <= (state_d != IDLE);
            if (state_q == IDLE && cfg_ok) begin
                ow_q       <= cfg_ow;
                oh_q       <= cfg_oh;
                total_q    <= cfg_total;
                rx_count_q <= '0;
                tx_count_q <= '0;
                overflow   <= 1'b0;
            end else begin
                if (push)   rx_count_q <= rx_count_q + COUNT_BITS'(1);
                if (pix_hs) tx_count_q <= tx_count_q + COUNT_BITS'(1);
                if (active && valid_in && !ready_in && rx_room) overflow <= 1'b1;
            end

            if (load_hdr) begin
                data_out  <= hdr_byte;
                valid_out <= 1'b1;
                out_pix_q <= 1'b0;
            end else if (load_pix) begin
                data_out  <= fifo_rdata;
                valid_out <= 1'b1;
                out_pix_q <= 1'b1;
            end else if (hs) begin
                valid_out <= 1'b0;
                out_pix_q <= 1'b0;
            end
        end
    end

endmodule

// File: doc/sobel_frame_packer.md
# sobel_frame_packer

- Downstream neighbour of the Sobel stage; feeds the UART transmitter.
- Buffers the Sobel stage's un-throttled output bytes in a small FIFO and prepends a 2-byte header (output width, output height).
- Streams the header and pixels over a valid/ready handshake, then signals frame completion.
- Output frame is (W-2)×(H-2) because the 3×3 Sobel window drops the one-pixel border.

## Interface

Parameters:
- DATA_BITS = 8: pixel/byte width.
- FIFO_DEPTH = 16: pixel FIFO entries, power of two, ≥ 2.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- cfg_valid  in  1  one-cycle strobe: input image dimensions available.
- cfg_width  in  8  input image width W.
- cfg_height  in  8  input image height H.
- data_in  in  DATA_BITS  Sobel result byte.
- valid_in  in  1  data_in valid; the upstream cannot stall.
- ready_in  out  1  FIFO can accept a byte.
- data_out  out  DATA_BITS  byte to the UART TX.
- valid_out  out  1  data_out valid.
- ready_out  in  1  UART TX accepts a byte.
- busy  out  1  high in every state except IDLE.
- frame_done  out  1  one-cycle pulse on the last pixel handshake.
- overflow  out  1  sticky: a byte was dropped.

## Operation

States: IDLE → HDR_W → HDR_H → PIXELS → IDLE.

IDLE:
- Accept cfg_valid only if W ≥ 3 and H ≥ 3; otherwise ignore it and stay in IDLE.
- On accept:
  - latch OW = W-2 and OH = H-2;
  - total = OW*OH, 16-bit unsigned, max 64009;
  - clear both counters and overflow;
  - go to HDR_W.
- cfg_valid in any other state is ignored.

HDR_W / HDR_H:
- Load OW (then OH) into the output register when it is free.
- Advance to the next state on that load.

PIXELS:
- Load the FIFO head into the output register when the register is free and the FIFO is not empty.
- tx_count increments on each pixel handshake (valid_out && ready_out).
- On the handshake with tx_count == total-1:
  - pulse frame_done;
  - return to IDLE.

Input acceptance (HDR_W, HDR_H, PIXELS):
- ready_in = !fifo_full && (rx_count < total).
- valid_in && ready_in: write to the FIFO, increment rx_count.
- valid_in && !ready_in while rx_count < total: drop the byte, set overflow.
- valid_in after rx_count == total: discard silently.
- ready_in = 0 in IDLE. valid_in in IDLE is discarded without setting overflow.

Output register:
- "Free" means !valid_out || ready_out.
- data_out holds stable while valid_out && !ready_out.

Simultaneous events:
- FIFO push and pop in the same cycle are both honoured; the count is unchanged.
- A full FIFO with a same-cycle pop still reports ready_in = 0 (no combinational path from ready_out to ready_in).

## Timing

- Reset values: all outputs 0 except ready_in (also 0, state IDLE); FIFO pointers 0; counters 0.
- Reset is asserted asynchronously mid-frame. The partial frame is lost; the first cfg_valid after release starts a clean frame.
- Header latency: cfg_valid sampled at edge E0 → OW on data_out after E1. With ready_out = 1, OH follows after E2.
- Pixel latency: a byte written at edge E0 can appear on data_out no earlier than after E1, i.e. one register stage. Header bytes always precede pixels.
- Throughput: one byte per cycle when ready_out = 1.
- frame_done is combinational on the final handshake cycle and high for exactly one cycle. busy falls on the following cycle.

## Structure

- Package sobel_pkg holds:
  - the state enum (packer_state_t: IDLE, HDR_W, HDR_H, PIXELS);
  - the constant PIXEL_BITS = 8;
  - the constant SOBEL_BORDER = 2.
- Sub-module sync_fifo (parameters WIDTH, DEPTH):
  - ports: push, pop, wdata, rdata, full, empty;
  - first-word-fall-through;
  - async active-high reset.
- The packer holds the FSM, both counters, the output register and the overflow flag.

## Test plan

- cfg 5×4, then push 0x10..0x15 (6 bytes) with ready_out = 1 → out 0x03, 0x02, 0x10..0x15 in order; frame_done pulses with 0x15; busy = 0 the next cycle.
- Same frame with ready_out toggling every other cycle → identical byte sequence; data_out never changes while valid_out && !ready_out.
- FIFO_DEPTH = 4, cfg 10×10, ready_out = 0, push 6 bytes:
  - ready_in drops after 4 bytes;
  - overflow = 1;
  - releasing ready_out gives 0x08, 0x08 then the first 4 bytes only.
- cfg 2×5 and cfg 5×1 → ignored; busy stays 0, valid_out stays 0.
- Reset pulsed asynchronously mid-PIXELS → valid_out, busy and overflow go 0 immediately; next cfg 4×4 + 4 pixels packs correctly.
- cfg_valid 9×9 during PIXELS of a 5×4 frame → ignored; the frame still ends after 6 pixels with header 0x03, 0x02.
